// File: rtl/ws2812_frame_rx_if.sv
// ws2812_frame_rx_if
// Groups the WS2812B serial input and the decoded pixel/frame outputs of
// ws2812_frame_rx into one bundle.
//   din        : serial WS2812B line (asynchronous to the sampling clock)
//   pix_valid  : one-cycle strobe, pix_rgb/pix_num valid
//   pix_rgb    : received 24-bit word, first wire bit in bit 23
//   pix_num    : pixel index within the frame
//   frame_done : one-cycle strobe at end of frame
//   frame_len  : complete pixels in the finished frame
//   bit_err    : one-cycle strobe on a timing error
//   overflow   : sticky, a pixel beyond the supported count was dropped
// Modports: slave = the receiver, master = the stream source / observer.
interface ws2812_frame_rx_if;
    logic        din;
    logic        pix_valid;
    logic [23:0] pix_rgb;
    logic [15:0] pix_num;
    logic        frame_done;
    logic [15:0] frame_len;
    logic        bit_err;
    logic        overflow;

    modport slave (
        input  din,
        output pix_valid, pix_rgb, pix_num, frame_done, frame_len, bit_err, overflow
    );

    modport master (
        output din,
        input  pix_valid, pix_rgb, pix_num, frame_done, frame_len, bit_err, overflow
    );
endinterface

// File: rtl/ws2812_frame_rx.sv
// ws2812_frame_rx
// Decodes a WS2812B single-wire stream into 24-bit pixel words with pixel
// indices and marks frame boundaries. All thresholds are in clk cycles.
// Ports:
//   clk   : sampling clock (100 MHz nominal)
//   rst_n : asynchronous active-low reset
//   bus   : ws2812_frame_rx_if.slave (din in; pixel/frame outputs)
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_SYNC | waiting for a full reset-length low before trusting the line
// S_IDLE | between frames, line low, waiting for the first rising edge
// S_HIGH | measuring a high pulse
// S_LOW  | measuring the low gap after a bit; long gap ends the frame
module ws2812_frame_rx #(
    parameter int GLITCH_CLKS   = 10,
    parameter int THRESH_CLKS   = 60,
    parameter int HIGH_MAX_CLKS = 120,
    parameter int RESET_CLKS    = 5000,
    parameter int MAX_LEDS      = 304
) (
    input  logic             clk,
    input  logic             rst_n,
    ws2812_frame_rx_if.slave bus
);

    localparam int HW = $clog2(HIGH_MAX_CLKS + 2);
    localparam int LW = $clog2(RESET_CLKS + 1);

    // high_cnt is loaded with 0 on the rising-edge cycle, so at the falling
    // edge it holds L-1; the limits below are shifted by one to match.
    localparam logic [HW-1:0] GL_M1    = HW'(GLITCH_CLKS - 1);
    localparam logic [HW-1:0] TH_M1    = HW'(THRESH_CLKS - 1);
    localparam logic [HW-1:0] HM_M1    = HW'(HIGH_MAX_CLKS - 1);
    localparam logic [HW-1:0] HIGH_SAT = HW'(HIGH_MAX_CLKS + 1);
    localparam logic [LW-1:0] LOW_TC   = LW'(RESET_CLKS - 1);
    localparam logic [15:0]   PIX_LIM  = 16'(MAX_LEDS);

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

    logic          r_sync1, r_sync2, r_dly;
    state_t        r_state, w_state_nxt;
    logic [HW-1:0] r_high_cnt, w_high_nxt;
    logic [LW-1:0] r_low_cnt, w_low_nxt;
    logic [4:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [23:0]   r_shift, w_shift_nxt;
    logic [15:0]   r_pix_idx, w_pix_idx_nxt;

    logic          r_pix_valid, w_pix_valid_nxt;
    logic [23:0]   r_pix_rgb, w_pix_rgb_nxt;
    logic [15:0]   r_pix_num, w_pix_num_nxt;
    logic          r_frame_done, w_frame_done_nxt;
    logic [15:0]   r_frame_len, w_frame_len_nxt;
    logic          r_bit_err, w_bit_err_nxt;
    logic          r_overflow, w_overflow_nxt;

    logic          w_rise, w_fall, w_bit;
    logic [23:0]   w_word;

    assign w_rise = r_sync2 & ~r_dly;
    assign w_fall = ~r_sync2 & r_dly;
    assign w_bit  = (r_high_cnt >= TH_M1);
    assign w_word = {r_shift[22:0], w_bit};

    always_comb begin
        w_state_nxt      = r_state;
        w_high_nxt       = r_high_cnt;
        w_low_nxt        = r_low_cnt;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_pix_idx_nxt    = r_pix_idx;
        w_pix_valid_nxt  = 1'b0;
        w_pix_rgb_nxt    = r_pix_rgb;
        w_pix_num_nxt    = r_pix_num;
        w_frame_done_nxt = 1'b0;
        w_frame_len_nxt  = r_frame_len;
        w_bit_err_nxt    = 1'b0;
        // overflow stays set through the frame_done cycle, then drops
        w_overflow_nxt   = r_overflow & ~r_frame_done;

        case (r_state)
            S_SYNC: begin
                if (r_sync2) begin
                    w_low_nxt = '0;
                end else if (r_low_cnt == LOW_TC) begin
                    w_low_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_low_nxt = r_low_cnt + 1'b1;
                end
            end

            S_IDLE: begin
                if (w_rise) begin
                    w_high_nxt  = '0;
                    w_state_nxt = S_HIGH;
                end
            end

            S_HIGH: begin
                if (w_fall) begin
                    w_state_nxt = S_LOW;
                    w_low_nxt   = '0;
                    if (r_high_cnt < GL_M1) begin
                        // glitch: keep the partial word untouched
                        w_bit_err_nxt = 1'b1;
                    end else if (r_high_cnt <= HM_M1) begin
                        w_shift_nxt = w_word;
                        if (r_bit_cnt == 5'd23) begin
                            w_bit_cnt_nxt = '0;
                            if (r_pix_idx < PIX_LIM) begin
                                w_pix_valid_nxt = 1'b1;
                                w_pix_rgb_nxt   = w_word;
                                w_pix_num_nxt   = r_pix_idx;
                            end else begin
                                w_overflow_nxt = 1'b1;
                            end
                            if (r_pix_idx != 16'hFFFF) begin
                                w_pix_idx_nxt = r_pix_idx + 16'd1;
                            end
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        end
                    end else begin
                        w_bit_err_nxt = 1'b1;
                        w_bit_cnt_nxt = '0;
                    end
                end else if (r_high_cnt != HIGH_SAT) begin
                    w_high_nxt = r_high_cnt + 1'b1;
                end
            end

            S_LOW: begin
                if (w_rise) begin
                    w_high_nxt  = '0;
                    w_low_nxt   = '0;
                    w_state_nxt = S_HIGH;
                end else if (r_low_cnt == LOW_TC) begin
                    w_low_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if ((r_pix_idx != 16'd0) || (r_bit_cnt != 5'd0)) begin
                        w_frame_done_nxt = 1'b1;
                        w_frame_len_nxt  = r_pix_idx;
                    end
                    if (r_bit_cnt != 5'd0) begin
                        w_bit_err_nxt = 1'b1;
                    end
                    w_pix_idx_nxt = '0;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_low_nxt = r_low_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_SYNC;
                w_low_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_dly        <= 1'b0;
            r_state      <= S_SYNC;
            r_high_cnt   <= '0;
            r_low_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_pix_idx    <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_rgb    <= '0;
            r_pix_num    <= '0;
            r_frame_done <= 1'b0;
            r_frame_len  <= '0;
            r_bit_err    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_sync1      <= bus.din;
            r_sync2      <= r_sync1;
            r_dly        <= r_sync2;
            r_state      <= w_state_nxt;
            r_high_cnt   <= w_high_nxt;
            r_low_cnt    <= w_low_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_pix_idx    <= w_pix_idx_nxt;
            r_pix_valid  <= w_pix_valid_nxt;
            r_pix_rgb    <= w_pix_rgb_nxt;
            r_pix_num    <= w_pix_num_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_frame_len  <= w_frame_len_nxt;
            r_bit_err    <= w_bit_err_nxt;
            r_overflow   <= w_overflow_nxt;
        end
    end

    assign bus.pix_valid  = r_pix_valid;
    assign bus.pix_rgb    = r_pix_rgb;
    assign bus.pix_num    = r_pix_num;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_len  = r_frame_len;
    assign bus.bit_err    = r_bit_err;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_ws2812_frame_rx.sv
// tb_ws2812_frame_rx
// Directed bench for ws2812_frame_rx. rx1 uses the default timing; rx2 uses
// shortened pulse/reset timing so a 306-pixel frame fits a short run while
// keeping the default 304-pixel limit.
module tb_ws2812_frame_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n2 = 1'b0;

    always #5 clk = ~clk;

    ws2812_frame_rx_if rx1 ();
    ws2812_frame_rx_if rx2 ();

    ws2812_frame_rx dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rx1)
    );

    ws2812_frame_rx #(
        .GLITCH_CLKS   (2),
        .THRESH_CLKS   (4),
        .HIGH_MAX_CLKS (8),
        .RESET_CLKS    (40),
        .MAX_LEDS      (304)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n2),
        .bus   (rx2)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // rx1 event log
    logic [23:0] rgb1 [0:63];
    logic [15:0] num1 [0:63];
    int          n_pv1   = 0;
    int          n_done1 = 0;
    int          n_err1  = 0;
    int          n_de1   = 0;
    logic [15:0] len1    = '0;

    always @(negedge clk) begin
        if (rx1.pix_valid) begin
            rgb1[n_pv1[5:0]] <= rx1.pix_rgb;
            num1[n_pv1[5:0]] <= rx1.pix_num;
            n_pv1 <= n_pv1 + 1;
        end
        if (rx1.frame_done) begin
            n_done1 <= n_done1 + 1;
            len1    <= rx1.frame_len;
        end
        if (rx1.bit_err) n_err1 <= n_err1 + 1;
        if (rx1.frame_done && rx1.bit_err) n_de1 <= n_de1 + 1;
    end

    // rx2 event log
    int          n_pv2        = 0;
    int          bad2         = 0;
    int          seq2         = 0;
    int          ovf_rise_pv2 = -1;
    int          n_done2      = 0;
    logic [15:0] len2         = '0;
    logic        ovf_at_done2 = 1'b0;
    logic        ovf_after2   = 1'b1;
    logic        done_prev2   = 1'b0;
    logic        ovf_prev2    = 1'b0;

    always @(negedge clk) begin
        if (rx2.pix_valid) begin
            if (rx2.pix_rgb !== 24'h123456) bad2 <= bad2 + 1;
            if (rx2.pix_num !== 16'(n_pv2)) seq2 <= seq2 + 1;
            n_pv2 <= n_pv2 + 1;
        end
        if (rx2.overflow && !ovf_prev2) ovf_rise_pv2 <= n_pv2;
        if (done_prev2) ovf_after2 <= rx2.overflow;
        if (rx2.frame_done) begin
            n_done2      <= n_done2 + 1;
            len2         <= rx2.frame_len;
            ovf_at_done2 <= rx2.overflow;
        end
        done_prev2 <= rx2.frame_done;
        ovf_prev2  <= rx2.overflow;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each level task starts on a negedge and returns on a negedge, so a
    // level held for n calls is sampled on exactly n rising edges.
    task automatic lvl1(input logic v, input int n);
        rx1.din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse1(input int h, input int l);
        lvl1(1'b1, h);
        lvl1(1'b0, l);
    endtask

    task automatic bit1(input logic b);
        if (b) pulse1(80, 45);
        else   pulse1(40, 85);
    endtask

    task automatic word1(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) bit1(w[i]);
    endtask

    task automatic lvl2(input logic v, input int n);
        rx2.din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit2(input logic b);
        lvl2(1'b1, b ? 4 : 2);
        lvl2(1'b0, 1);
    endtask

    task automatic word2(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) bit2(w[i]);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_pix_valid"},  64'(rx1.pix_valid),  64'd0);
        check({pfx, "_pix_rgb"},    64'(rx1.pix_rgb),    64'd0);
        check({pfx, "_pix_num"},    64'(rx1.pix_num),    64'd0);
        check({pfx, "_frame_done"}, 64'(rx1.frame_done), 64'd0);
        check({pfx, "_frame_len"},  64'(rx1.frame_len),  64'd0);
        check({pfx, "_bit_err"},    64'(rx1.bit_err),    64'd0);
        check({pfx, "_overflow"},   64'(rx1.overflow),   64'd0);
    endtask

    initial begin
        int b_pv, b_done, b_err, b_de;
        logic [20:0] rem;
        logic [13:0] junk14;
        logic [9:0]  part10;
        logic [11:0] part12;
        logic [23:0] w3;

        rx1.din = 1'b0;
        rx2.din = 1'b0;
        rem     = 21'h0A5A5;
        junk14  = 14'h3A5F;
        part10  = 10'b1011001110;
        part12  = 12'hABC;
        w3      = 24'h5A3C96;

        repeat (3) @(negedge clk);
        check("rst_pix_valid", 64'(rx1.pix_valid), 64'd0);
        check("rst_frame_done", 64'(rx1.frame_done), 64'd0);
        check("rst_overflow", 64'(rx1.overflow), 64'd0);
        check("rst2_overflow", 64'(rx2.overflow), 64'd0);
        rst_n  = 1'b1;
        rst_n2 = 1'b1;

        fork
            begin
                // stream joined mid-frame: nothing until a full reset gap
                for (int i = 13; i >= 0; i--) bit1(junk14[i]);
                lvl1(1'b0, 5100);
                check("sync_no_pix", 64'(n_pv1), 64'd0);
                check("sync_no_done", 64'(n_done1), 64'd0);
                check("sync_no_err", 64'(n_err1), 64'd0);

                // three-pixel frame
                word1(24'hFF0000);
                word1(24'h00FF00);
                word1(24'h0000A5);
                lvl1(1'b0, 5100);
                check("f3_n_pix", 64'(n_pv1), 64'd3);
                check("f3_rgb0", 64'(rgb1[0]), 64'hFF0000);
                check("f3_rgb1", 64'(rgb1[1]), 64'h00FF00);
                check("f3_rgb2", 64'(rgb1[2]), 64'h0000A5);
                check("f3_num0", 64'(num1[0]), 64'd0);
                check("f3_num1", 64'(num1[1]), 64'd1);
                check("f3_num2", 64'(num1[2]), 64'd2);
                check("f3_n_done", 64'(n_done1), 64'd1);
                check("f3_len", 64'(len1), 64'd3);
                check("f3_no_err", 64'(n_err1), 64'd0);

                // boundary pulse widths, long-pulse discard, glitch
                b_pv = n_pv1; b_done = n_done1; b_err = n_err1;
                pulse1(59, 85);
                pulse1(60, 85);
                pulse1(120, 85);
                for (int i = 20; i >= 0; i--) bit1(rem[i]);
                for (int i = 0; i < 5; i++) bit1(1'b1);
                pulse1(121, 85);
                for (int i = 23; i >= 0; i--) begin
                    bit1(w3[i]);
                    if (i == 12) pulse1(9, 85);
                end
                lvl1(1'b0, 5100);
                check("bnd_n_pix", 64'(n_pv1 - b_pv), 64'd2);
                check("bnd_rgb0", 64'(rgb1[6'(b_pv)]), 64'h60A5A5);
                check("bnd_num0", 64'(num1[6'(b_pv)]), 64'd0);
                check("bnd_rgb1", 64'(rgb1[6'(b_pv + 1)]), 64'h5A3C96);
                check("bnd_num1", 64'(num1[6'(b_pv + 1)]), 64'd1);
                check("bnd_n_err", 64'(n_err1 - b_err), 64'd2);
                check("bnd_n_done", 64'(n_done1 - b_done), 64'd1);
                check("bnd_len", 64'(len1), 64'd2);

                // partial word at frame end
                b_pv = n_pv1; b_done = n_done1; b_err = n_err1; b_de = n_de1;
                for (int i = 9; i >= 0; i--) bit1(part10[i]);
                lvl1(1'b0, 5100);
                check("part_n_done", 64'(n_done1 - b_done), 64'd1);
                check("part_len", 64'(len1), 64'd0);
                check("part_n_err", 64'(n_err1 - b_err), 64'd1);
                check("part_done_with_err", 64'(n_de1 - b_de), 64'd1);
                check("part_no_pix", 64'(n_pv1 - b_pv), 64'd0);

                // reset mid-word
                for (int i = 11; i >= 0; i--) bit1(part12[i]);
                rx1.din = 1'b0;
                rst_n   = 1'b0;
                #1;
                check_outputs_zero("midrst");
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                b_pv = n_pv1; b_done = n_done1; b_err = n_err1;
                lvl1(1'b0, 5100);
                word1(24'hC33C0F);
                lvl1(1'b0, 5100);
                check("after_rst_n_pix", 64'(n_pv1 - b_pv), 64'd1);
                check("after_rst_rgb", 64'(rgb1[6'(b_pv)]), 64'hC33C0F);
                check("after_rst_num", 64'(num1[6'(b_pv)]), 64'd0);
                check("after_rst_n_done", 64'(n_done1 - b_done), 64'd1);
                check("after_rst_len", 64'(len1), 64'd1);
                check("after_rst_no_err", 64'(n_err1 - b_err), 64'd0);
            end
            begin
                lvl2(1'b0, 50);
                for (int p = 0; p < 306; p++) word2(24'h123456);
                lvl2(1'b0, 60);
            end
        join

        check("ovf_n_pix", 64'(n_pv2), 64'd304);
        check("ovf_bad_rgb", 64'(bad2), 64'd0);
        check("ovf_num_seq", 64'(seq2), 64'd0);
        check("ovf_rise_after_304", 64'(ovf_rise_pv2), 64'd304);
        check("ovf_n_done", 64'(n_done2), 64'd1);
        check("ovf_len", 64'(len2), 64'd306);
        check("ovf_at_done", 64'(ovf_at_done2), 64'd1);
        check("ovf_cleared_after_done", 64'(ovf_after2), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
